// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard, flush and multiply/divide stall controller
// Optional iterative multiply/divide handshake and watchdog enabled by PIPE_MULDIV_EN.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_IFID,
    input  logic [4:0]  rs2_IFID,
    input  logic [4:0]  rd_IDEX,
    input  logic        mem_rd_IDEX,
    input  logic        pc_sel_EXIF,
    input  logic        md_start_IDEX,
    input  logic        md_done,
    output logic        stall_IF,
    output logic        stall_ID,
    output logic        stall_EX,
    output logic        flush_IFID,
    output logic        flush_IDEX,
    output logic        bubble_EXMEM,
    output logic        md_go,
    output logic        md_sel,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [15:0] stall_count
);

    logic load_use;
    assign load_use = mem_rd_IDEX && (rd_IDEX != 5'd0) &&
                      ((rd_IDEX == rs1_IFID) || (rd_IDEX == rs2_IFID));

`ifdef PIPE_MULDIV_EN
    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    state_t     state;
    logic [5:0] wait_cnt;
    logic       timeout_q;
    logic       in_wait;
    logic       timeout_now;

    assign in_wait     = (state == MD_WAIT);
    assign timeout_now = in_wait && !md_done && (wait_cnt == 6'd63);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 6'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // a taken branch squashes the md op sitting in EX
                    if (!pc_sel_EXIF && md_start_IDEX) begin
                        state    <= MD_WAIT;
                        wait_cnt <= 6'd0;
                    end
                end
                MD_WAIT: begin
                    if (md_done || timeout_now) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                    if (timeout_now) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign md_busy    = !reset && in_wait;
    assign md_timeout = !reset && (timeout_q || timeout_now);
`else
    logic unused_md_inputs;
    assign unused_md_inputs = &{1'b0, md_start_IDEX, md_done};
    assign md_busy    = 1'b0;
    assign md_timeout = 1'b0;
`endif

    always_comb begin
        stall_IF     = 1'b0;
        stall_ID     = 1'b0;
        stall_EX     = 1'b0;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;
        bubble_EXMEM = 1'b0;
        md_go        = 1'b0;
        md_sel       = 1'b0;
        if (!reset) begin
`ifdef PIPE_MULDIV_EN
            if (in_wait) begin
                if (md_done) begin
                    md_sel = 1'b1;
                end else if (!timeout_now) begin
                    stall_IF     = 1'b1;
                    stall_ID     = 1'b1;
                    stall_EX     = 1'b1;
                    bubble_EXMEM = 1'b1;
                end
            end else if (pc_sel_EXIF) begin
`else
            if (pc_sel_EXIF) begin
`endif
                flush_IFID = 1'b1;
                flush_IDEX = 1'b1;
            end
`ifdef PIPE_MULDIV_EN
            else if (md_start_IDEX) begin
                md_go        = 1'b1;
                stall_IF     = 1'b1;
                stall_ID     = 1'b1;
                stall_EX     = 1'b1;
                bubble_EXMEM = 1'b1;
            end
`endif
            else if (load_use) begin
                stall_IF   = 1'b1;
                stall_ID   = 1'b1;
                flush_IDEX = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (stall_IF && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
REQ-002 rs1_IFID, rs2_IFID  in  5 each  source register fields of the instruction in ID.
REQ-003 rd_IDEX  in  5  destination register of the instruction in EX.
REQ-004 mem_rd_IDEX  in  1  instruction in EX is a load.
REQ-005 pc_sel_EXIF  in  1  taken branch or jump resolved in EX.
REQ-006 md_start_IDEX  in  1  instruction in EX is a multiply/divide op.
REQ-007 md_done  in  1  iterative multiply/divide unit has its result valid this cycle.
REQ-008 Control outputs:
- stall_IF, stall_ID, stall_EX  out  1 each  hold the PC, IF/ID and ID/EX registers respectively.
- flush_IFID, flush_IDEX  out  1 each  clear the named pipeline register to a bubble on the next edge.
- bubble_EXMEM  out  1  force reg_wr_en and mem_wr_en to 0 into EX/MEM.
REQ-009 Multiply/divide outputs:
- md_go  out  1  one-cycle start pulse to the multiply/divide unit.
- md_sel  out  1  select the multiply/divide result onto ALU_out_EX.
- md_busy  out  1  FSM is in MD_WAIT.
REQ-010 Status outputs:
- md_timeout  out  1  sticky watchdog error flag.
- stall_count  out  16  saturating count of cycles with stall_IF=1.

Function
REQ-011 The FSM SHALL have exactly two states, RUN and MD_WAIT, encoded in 1 bit.
REQ-012 RUN, priority 1: pc_sel_EXIF=1 SHALL assert flush_IFID=1 and flush_IDEX=1 with no stall; load-use and md_start SHALL be ignored that cycle.
REQ-013 RUN, priority 2: md_start_IDEX=1 SHALL, in the same cycle, assert md_go=1, stall_IF=stall_ID=stall_EX=1 and bubble_EXMEM=1; next state MD_WAIT.
REQ-014 RUN, priority 3 (load-use): mem_rd_IDEX=1, rd_IDEX!=0 and rd_IDEX equal to rs1_IFID or rs2_IFID SHALL, in the same cycle, assert stall_IF=stall_ID=1 and flush_IDEX=1. The stall SHALL last exactly one cycle, because the bubble clears mem_rd_IDEX.
REQ-015 In MD_WAIT with md_done=0, the block SHALL assert stall_IF=stall_ID=stall_EX=1 and bubble_EXMEM=1, and SHALL ignore load-use and pc_sel_EXIF.
REQ-016 In MD_WAIT with md_done=1, the block SHALL assert md_sel=1 and SHALL deassert all stalls and bubble_EXMEM that cycle; next state RUN.
REQ-017 md_go SHALL never be asserted in MD_WAIT; md_busy SHALL be 1 exactly when state=MD_WAIT.
REQ-018 A 6-bit wait counter SHALL clear on entry to MD_WAIT and increment each MD_WAIT cycle with md_done=0.
REQ-019 If the wait counter reaches 63 with md_done=0, the block SHALL:
- set md_timeout=1, held until reset;
- in that cycle, drop all stalls and bubble_EXMEM with md_sel=0;
- return to RUN.
REQ-020 stall_count SHALL increment on every cycle with stall_IF=1 and SHALL saturate at 16'hFFFF.
REQ-021 All outputs except state-derived flags SHALL be combinational from the current state and inputs. No output SHALL depend combinationally on stall_count.

Reset
REQ-022 Asserting reset SHALL immediately set state=RUN, wait counter=0, stall_count=0 and md_timeout=0, including in the middle of MD_WAIT.
REQ-023 While reset=1, every output SHALL be 0 regardless of the other inputs.

Configuration
REQ-024 With macro PIPE_MULDIV_EN defined, the block SHALL implement MD_WAIT, md_go, md_sel, md_busy, the watchdog and md_timeout as specified above.
REQ-025 With PIPE_MULDIV_EN undefined:
- md_start_IDEX and md_done SHALL be ignored;
- md_go, md_sel, md_busy and md_timeout SHALL be tied to 0;
- the FSM and wait counter SHALL be removed, leaving only the flush and load-use logic plus stall_count.

Verification
REQ-026 Load-use: rd_IDEX=5, mem_rd_IDEX=1, rs2_IFID=5 -> stall_IF=stall_ID=flush_IDEX=1 for 1 cycle; stall_count=1.
REQ-027 Load to x0: rd_IDEX=0, mem_rd_IDEX=1, rs1_IFID=0 -> no stall, no flush.
REQ-028 Branch beats load-use: pc_sel_EXIF=1 together with a load-use match -> flush_IFID=flush_IDEX=1, stall_IF=0.
REQ-029 Multiply/divide (PIPE_MULDIV_EN defined): md_start_IDEX for 1 cycle, md_done 4 cycles later ->
- md_go pulse on cycle 0 only;
- stalls high on cycles 0-3;
- md_sel=1 with stalls low on cycle 4;
- stall_count=4.
REQ-030 Watchdog: md_start_IDEX with md_done held at 0 -> md_timeout=1 and return to RUN 63 cycles after MD_WAIT entry; flag still 1 after 10 more cycles.
REQ-031 Reset mid-wait: assert reset at MD_WAIT cycle 3 -> all outputs 0 asynchronously; after release, md_start_IDEX restarts cleanly with md_go=1.
